// File: rtl/fifo_rd_pkg.sv
// Shared types/constants for the FIFO read-side stream master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_rd_pkg;

    // Width of the optional statistics counters.
    localparam int STAT_W = 16;

    // Default FIFO word / stream data width.
    localparam int DEF_DATA_WIDTH = 4;

    // Width needed to hold an occupancy value in 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Ring buffer holding words captured from the FIFO until the stream consumer takes them.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: pop_vld/pop_dat hold while pop_rdy is low; the caller must never push into a full buffer.
//
// Ports:
//   clk, rstN            clock, async active-low reset
//   push_vld, push_dat   write one word at wr_ptr (unconditional when push_vld)
//   pop_vld, pop_dat     head word, pop_dat forced to 0 when empty
//   pop_rdy              consumer accepts the head word when pop_vld is high
//   count                current occupancy (registered)
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  BUF_DEPTH  = 3,
    localparam int LVL_W      = level_w(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop_rdy,
    output logic                  pop_vld,
    output logic [DATA_WIDTH-1:0] pop_dat,
    output logic [LVL_W-1:0]      count
);

    localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  pop_fire;

    // Explicit wrap at the last entry so non-power-of-2 depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_vld  = (count != '0);
    assign pop_fire = pop_vld && pop_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    // Storage is not reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            unique case ({push_vld, pop_fire})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstN)
        !(push_vld && !pop_fire && (count == FULL_LVL)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rstN)
        count <= FULL_LVL);

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for a FIFO: issues read_en, captures read data one cycle later, re-presents it as valid/ready.
// Latency: FIFO word present -> out_vld is 2 cycles; 1 word/cycle sustained when BUF_DEPTH >= 3 and out_rdy high.
// Backpressure: out_vld/out_data hold while stalled; reads stop once buffered + in-flight words fill the buffer.
//
// Ports:
//   clk, rstN                      clock, async active-low reset (also resets the attached FIFO)
//   fifo_empty, fifo_read_en       FIFO read-side handshake; read_en never asserted while empty
//   fifo_read_data                 FIFO data, valid the cycle after an accepted read
//   out_vld, out_data, out_rdy     downstream stream
//   buf_level                      buffer occupancy (registered)
//   stat_words, stat_stall         saturating handshake / stall-cycle counters,
//                                  present only when FIFO_RD_STREAM_STATS_EN is defined
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  BUF_DEPTH  = 3,
    localparam int LVL_W      = level_w(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_rdy,
`ifdef FIFO_RD_STREAM_STATS_EN
    output logic [STAT_W-1:0]     stat_words,
    output logic [STAT_W-1:0]     stat_stall,
`endif
    output logic [LVL_W-1:0]      buf_level
);

    localparam logic [LVL_W:0] DEPTH_EXT = (LVL_W + 1)'(BUF_DEPTH);

    logic             inflight;
    logic [LVL_W-1:0] count;
    logic [LVL_W:0]   occ_sum;

    // A read issued last cycle has not landed yet but already owns a buffer slot.
    assign occ_sum      = {1'b0, count} + (LVL_W + 1)'(inflight);
    assign fifo_read_en = rstN && !fifo_empty && (occ_sum < DEPTH_EXT);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read_en;
        end
    end

    // Capture is unconditional when a read is in flight; fifo_empty in that cycle is irrelevant.
    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rstN     (rstN),
        .push_vld (inflight),
        .push_dat (fifo_read_data),
        .pop_rdy  (out_rdy),
        .pop_vld  (out_vld),
        .pop_dat  (out_data),
        .count    (count)
    );

    assign buf_level = count;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STAT_W-1:0] stat_words_q;
    logic [STAT_W-1:0] stat_stall_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (out_vld && out_rdy && (stat_words_q != '1)) begin
                stat_words_q <= stat_words_q + STAT_W'(1);
            end
            if (out_vld && !out_rdy && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + STAT_W'(1);
            end
        end
    end

    assign stat_words = stat_words_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO source, handshake monitor, directed scenarios.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Stats scenario is compiled only when FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rstN;
    logic       fifo_empty;
    logic       fifo_read_en;
    logic [3:0] fifo_read_data;
    logic       out_vld;
    logic [3:0] out_data;
    logic       out_rdy;
    logic [1:0] buf_level;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stall;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(4), .BUF_DEPTH(3)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_read_data (fifo_read_data),
        .out_vld        (out_vld),
        .out_data       (out_data),
        .out_rdy        (out_rdy),
`ifdef FIFO_RD_STREAM_STATS_EN
        .stat_words     (stat_words),
        .stat_stall     (stat_stall),
`endif
        .buf_level      (buf_level)
    );

    // Behavioural FIFO: words src[src_rd .. src_len-1] are queued; reset empties it.
    logic [3:0] src [0:1023];
    int         src_len = 0;
    int         src_rd  = 0;

    assign fifo_empty = (src_rd >= src_len);

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            src_rd         <= 0;
            fifo_read_data <= 4'h0;
        end else if (fifo_read_en && src_rd < 1024) begin
            fifo_read_data <= src[src_rd];
            src_rd         <= src_rd + 1;
        end
    end

    // Monitor: records every delivered word and every read pulse.
    logic [3:0] got [$];
    int         rd_pulses = 0;

    always @(negedge clk) begin
        if (rstN) begin
            if (fifo_read_en) rd_pulses <= rd_pulses + 1;
            if (out_vld && out_rdy) got.push_back(out_data);
        end
    end

    task automatic load(input logic [3:0] w);
        src[src_len] = w;
        src_len      = src_len + 1;
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        out_rdy = 1'b0;
        src_len = 0;
        repeat (2) @(negedge clk);
        load(4'h9);
        #1;
        n_chk++; if (fifo_read_en !== 1'b0) $display("FAIL reset_rd_en_forced: got %b want 0", fifo_read_en); else n_pass++;
        n_chk++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b want 0", out_vld); else n_pass++;
        n_chk++; if (out_data !== 4'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_chk++; if (buf_level !== 2'd0) $display("FAIL reset_buf_level: got %0d want 0", buf_level); else n_pass++;
        src_len = 0;
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_chk++; if (fifo_read_en !== 1'b0) $display("FAIL idle_rd_en c%0d: got %b want 0", k, fifo_read_en); else n_pass++;
            n_chk++; if (out_vld !== 1'b0) $display("FAIL idle_out_vld c%0d: got %b want 0", k, out_vld); else n_pass++;
            n_chk++; if (buf_level !== 2'd0) $display("FAIL idle_buf_level c%0d: got %0d want 0", k, buf_level); else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic       e_rd  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       e_vld [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_dat [6] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        int base;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                base    = got.size();
                out_rdy = 1'b1;
                load(4'h1); load(4'h2); load(4'h3);
            end
            @(negedge clk);
            n_chk++; if (fifo_read_en !== e_rd[k]) $display("FAIL basic_rd_en c%0d: got %b want %b", k, fifo_read_en, e_rd[k]); else n_pass++;
            n_chk++; if (out_vld !== e_vld[k]) $display("FAIL basic_out_vld c%0d: got %b want %b", k, out_vld, e_vld[k]); else n_pass++;
            n_chk++; if (out_data !== e_dat[k]) $display("FAIL basic_out_data c%0d: got %h want %h", k, out_data, e_dat[k]); else n_pass++;
        end
        @(posedge clk); #1;
        n_chk++; if (got.size() - base != 3) $display("FAIL basic_word_count: got %0d want 3", got.size() - base); else n_pass++;
    endtask

    task automatic test_stall();
        logic       e_rd  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] e_lvl [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [3:0] e_dat [8] = '{4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
        logic [3:0] words [6] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        int base, base_rd;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                base    = got.size();
                base_rd = rd_pulses;
                out_rdy = 1'b0;
                for (int i = 0; i < 6; i++) load(words[i]);
            end
            @(negedge clk);
            n_chk++; if (fifo_read_en !== e_rd[k]) $display("FAIL stall_rd_en c%0d: got %b want %b", k, fifo_read_en, e_rd[k]); else n_pass++;
            n_chk++; if (buf_level !== e_lvl[k]) $display("FAIL stall_buf_level c%0d: got %0d want %0d", k, buf_level, e_lvl[k]); else n_pass++;
            n_chk++; if (out_data !== e_dat[k]) $display("FAIL stall_out_data c%0d: got %h want %h", k, out_data, e_dat[k]); else n_pass++;
        end
        @(posedge clk); #1;
        n_chk++; if (rd_pulses - base_rd != 3) $display("FAIL stall_read_pulses: got %0d want 3", rd_pulses - base_rd); else n_pass++;
        out_rdy = 1'b1;
        repeat (16) begin @(posedge clk); #1; end
        n_chk++; if (got.size() - base != 6) $display("FAIL stall_drain_count: got %0d want 6", got.size() - base); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (base + i >= got.size()) $display("FAIL stall_drain_word%0d: got none want %h", i, words[i]);
            else if (got[base + i] !== words[i]) $display("FAIL stall_drain_word%0d: got %h want %h", i, got[base + i], words[i]);
            else n_pass++;
        end
        n_chk++; if (rd_pulses - base_rd != 6) $display("FAIL stall_total_reads: got %0d want 6", rd_pulses - base_rd); else n_pass++;
        n_chk++; if (buf_level !== 2'd0) $display("FAIL stall_final_level: got %0d want 0", buf_level); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [3:0] exp_w [220];
        int  base;
        int  occ  = 0;
        int  done = 0;
        logic rd_m1 = 1'b0, rd_m2 = 1'b0, hs_m1 = 1'b0;
        for (int k = 0; k < 900; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                base = got.size();
                for (int i = 0; i < 220; i++) begin
                    exp_w[i] = 4'(i * 5 + 1);
                    load(exp_w[i]);
                end
            end
            if (got.size() - base >= 220) begin
                done = 1;
                break;
            end
            out_rdy = k[0];
            @(negedge clk);
            // Expected occupancy: words captured from reads two cycles back, minus last cycle's handshake.
            occ = occ + int'(rd_m2) - int'(hs_m1);
            n_chk++; if ($isunknown(buf_level) || int'(buf_level) != occ) $display("FAIL alt_buf_level c%0d: got %0d want %0d", k, buf_level, occ); else n_pass++;
            n_chk++; if (occ > 3 || occ < 0) $display("FAIL alt_occ_range c%0d: got %0d want 0..3", k, occ); else n_pass++;
            rd_m2 = rd_m1;
            rd_m1 = fifo_read_en;
            hs_m1 = out_vld && out_rdy;
        end
        out_rdy = 1'b1;
        n_chk++; if (done != 1) $display("FAIL alt_timeout: got %0d words want 220", got.size() - base); else n_pass++;
        for (int i = 0; i < 220; i++) begin
            n_chk++;
            if (base + i >= got.size()) $display("FAIL alt_word%0d: got none want %h", i, exp_w[i]);
            else if (got[base + i] !== exp_w[i]) $display("FAIL alt_word%0d: got %h want %h", i, got[base + i], exp_w[i]);
            else n_pass++;
        end
        repeat (4) begin @(posedge clk); #1; end
        n_chk++; if (got.size() - base != 220) $display("FAIL alt_extra_words: got %0d want 220", got.size() - base); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                out_rdy = 1'b0;
                load(4'hC); load(4'hD); load(4'hE); load(4'hF); load(4'h1); load(4'h2);
            end
            @(negedge clk);
        end
        n_chk++; if (buf_level !== 2'd2) $display("FAIL mid_pre_level: got %0d want 2", buf_level); else n_pass++;
        // Reset lands mid-cycle while a read is in flight.
        #2;
        rstN    = 1'b0;
        src_len = 0;
        #1;
        n_chk++; if (out_vld !== 1'b0) $display("FAIL mid_rst_out_vld: got %b want 0", out_vld); else n_pass++;
        n_chk++; if (out_data !== 4'h0) $display("FAIL mid_rst_out_data: got %h want 0", out_data); else n_pass++;
        n_chk++; if (buf_level !== 2'd0) $display("FAIL mid_rst_buf_level: got %0d want 0", buf_level); else n_pass++;
        n_chk++; if (fifo_read_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %b want 0", fifo_read_en); else n_pass++;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rstN    = 1'b1;
        base    = got.size();
        out_rdy = 1'b1;
        load(4'h7); load(4'hB);
        repeat (8) begin @(posedge clk); #1; end
        n_chk++; if (got.size() - base != 2) $display("FAIL mid_post_count: got %0d want 2", got.size() - base); else n_pass++;
        n_chk++; if (got.size() < base + 1 || got[base] !== 4'h7) $display("FAIL mid_post_first: got %h want 7", (got.size() > base) ? got[base] : 4'hx); else n_pass++;
        n_chk++; if (got.size() < base + 2 || got[base + 1] !== 4'hB) $display("FAIL mid_post_second: got %h want b", (got.size() > base + 1) ? got[base + 1] : 4'hx); else n_pass++;
    endtask

`ifdef FIFO_RD_STREAM_STATS_EN
    task automatic test_stats();
        @(posedge clk); #1;
        rstN    = 1'b0;
        src_len = 0;
        out_rdy = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        n_chk++; if (stat_words !== 16'h0) $display("FAIL stats_rst_words: got %h want 0", stat_words); else n_pass++;
        n_chk++; if (stat_stall !== 16'h0) $display("FAIL stats_rst_stall: got %h want 0", stat_stall); else n_pass++;
        // Words visible from cycle 2; stalled through cycle 8 -> 7 stall cycles, then 5 handshakes.
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                load(4'h1); load(4'h2); load(4'h3); load(4'h4); load(4'h5);
            end
            out_rdy = (k >= 9);
            @(negedge clk);
        end
        n_chk++; if (stat_words !== 16'd5) $display("FAIL stats_words: got %0d want 5", stat_words); else n_pass++;
        n_chk++; if (stat_stall !== 16'd7) $display("FAIL stats_stall: got %0d want 7", stat_stall); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) load(4'h3);
            if (k == 2) dut.stat_stall_q = 16'hFFFE;
            out_rdy = (k >= 6);
            @(negedge clk);
            if (k >= 3 && k <= 5) begin
                n_chk++; if (stat_stall !== 16'hFFFF) $display("FAIL stats_saturate c%0d: got %h want ffff", k, stat_stall); else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_alternate();
        test_reset_mid();
`ifdef FIFO_RD_STREAM_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
